ysyx_25060173_mem_arbiter: RTL and testbench
============================================

# ysyx_25060173_mem_arbiter

Shares the single physical memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) as the core moves from single-cycle DPI access to multicycle handshaked memory. It arbitrates, registers one request at a time, sequences it to memory, routes the response back and covers misalignment and memory timeout. It sits between the core's IFU/LSU and the memory/bus adapter.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles in WAIT before error response (≥1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_req_addr  in  ADDR_W  fetch address (always word read)
- ifu_resp_valid  out  1  one-cycle response pulse to IFU
- ifu_resp_data  out  DATA_W  fetched word
- ifu_resp_err  out  1  misaligned or timeout
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_addr  in  ADDR_W;  lsu_req_we  in  1;  lsu_req_size  in  2 (0 byte, 1 half, 2 word, 3 illegal);  lsu_req_wdata  in  DATA_W
- lsu_resp_valid  out  1;  lsu_resp_data  out  DATA_W;  lsu_resp_err  out  1
- mem_req_valid  out  1;  mem_req_ready  in  1  memory request handshake
- mem_addr  out  ADDR_W;  mem_we  out  1;  mem_size  out  2;  mem_wdata  out  DATA_W
- mem_resp_valid  in  1;  mem_resp_data  in  DATA_W  memory response (writes also respond)

## Operation
- FSM: IDLE, ISSUE, WAIT, ERR.
- IDLE: ifu_req_ready = lsu_req_ready = grant to that requester (only one ready per cycle; ready only in IDLE). Handshake captures addr/we/size/wdata and owner id into registers.
- Arbitration: round-robin 2-way; pointer names the preferred requester, flips to the other after each grant. Single requester wins regardless of pointer. Reset pointer = LSU.
- Alignment check on accept: half with addr[0]≠0, word with addr[1:0]≠0, size 3 → ERR; else ISSUE. IFU treated as size 2, we 0.
- ISSUE: mem_req_valid=1, mem_* driven from registers, held stable until mem_req_ready; then WAIT.
- WAIT: cycle counter increments; mem_resp_valid → latch data, pulse owner resp_valid with err=0, go IDLE. Counter reaching TIMEOUT → pulse owner resp_valid with err=1, data 0, go IDLE.
- ERR: pulse owner resp_valid, err=1, data 0, next IDLE; memory never touched.
- mem_resp_valid outside WAIT (including late response after timeout) is dropped.
- Non-owner resp_valid always 0. Read data returned raw; byte/half extension is LSU's job.

## Timing
- Reset: state IDLE, all *_ready, *_resp_valid, *_resp_err, mem_req_valid, mem_we = 0; data/addr/size outputs 0; counter 0; pointer LSU. Readies rise the first cycle after reset deasserts.
- Accept at edge N → mem_req_valid high from cycle N+1.
- mem_resp_valid sampled at edge M → owner resp_valid high cycle M+1 only; readies high in that same cycle (back-to-back accept allowed).
- Minimum round trip (mem_req_ready immediate, response next cycle): accept N, response pulse N+3.
- Misaligned: accept N, err pulse cycle N+1.
- Timeout: err pulse exactly TIMEOUT cycles after entering WAIT.
- Reset mid-transaction: immediate abort, no response pulse, outputs to reset values.

## Structure
- Package ysyx_25060173_mem_pkg: state enum, size encodings (SZ_B/SZ_H/SZ_W), owner id constants, alignment-check function.
- Sub-module ysyx_25060173_rr_arbiter: 2-input round-robin grant with pointer register, advance on accept.

## Test plan
- IFU only, addr 0x80000000, mem_req_ready=1, response 0x00100093 next cycle → ifu_resp_valid at N+3, data 0x00100093, err 0.
- Both valid same cycle after reset → LSU granted first, IFU second; both still valid again → IFU then LSU alternate.
- LSU sh to 0x80000101 → lsu_resp_err=1 at N+1, mem_req_valid never asserted; lw 0x80000004 size 2 → issued normally.
- mem_req_ready held low 5 cycles → mem_addr/mem_wdata stable throughout, issue completes on 6th cycle.
- TIMEOUT=4, no mem_resp_valid → err pulse 4 cycles into WAIT; late mem_resp_valid in IDLE produces no pulse.
- reset asserted during WAIT → outputs zero asynchronously, no response pulse after release, next request served normally.

Source files
------------

// File: rtl/ysyx_25060173_mem_pkg.sv
// Shared types and helpers for the IFU/LSU memory arbiter.
// State encoding, access sizes, owner ids and the alignment rule.
package ysyx_25060173_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_X = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25060173_mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-port handshakes around the arbiter.
// slave is the arbiter's view, master is the surrounding core/memory.
interface ysyx_25060173_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_we;
    logic [1:0]        lsu_req_size;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              lsu_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid,
        output ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr,
        input  lsu_req_we, lsu_req_size,
        input  lsu_req_wdata,
        output lsu_req_ready, lsu_resp_valid,
        output lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_addr,
        output mem_we, mem_size, mem_wdata,
        input  mem_req_ready, mem_resp_valid,
        input  mem_resp_data
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid,
        input  ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr,
        output lsu_req_we, lsu_req_size,
        output lsu_req_wdata,
        input  lsu_req_ready, lsu_resp_valid,
        input  lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_addr,
        input  mem_we, mem_size, mem_wdata,
        output mem_req_ready, mem_resp_valid,
        output mem_resp_data
    );

endinterface

// File: rtl/ysyx_25060173_rr_arbiter.sv
// Two-way round-robin grant; pointer names the preferred requester
// and moves to the other one after every accepted grant.
module ysyx_25060173_rr_arbiter
    import ysyx_25060173_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;
    logic pick;

    // A lone requester wins; otherwise (both or none) follow the pointer.
    always_comb begin
        pick = ptr_q;
        unique case (1'b1)
            (req_i == 2'b01): pick = OWN_IFU;
            (req_i == 2'b10): pick = OWN_LSU;
            default:          pick = ptr_q;
        endcase
    end

    assign gnt_o = !en_i ? 2'b00 : (pick ? 2'b10 : 2'b01);
    assign ptr_d = (en_i && accept_i) ? ~pick : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= OWN_LSU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ysyx_25060173_mem_arbiter.sv
// Shares one memory port between IFU and LSU: one registered request
// at a time, with misalignment and response-timeout error replies.
module ysyx_25060173_mem_arbiter
    import ysyx_25060173_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                         clk,
    input logic                         reset,
    ysyx_25060173_mem_arbiter_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              arb_en;
    logic              accept;
    logic              pick_lsu;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [1:0]        cap_size;
    logic [DATA_W-1:0] cap_wdata;

    assign req      = {bus.lsu_req_valid, bus.ifu_req_valid};
    assign arb_en   = (state_q == ST_IDLE) && !reset;
    assign accept   = |(req & gnt);
    assign pick_lsu = gnt[1];

    ysyx_25060173_rr_arbiter u_arb (
        .clk      (clk),
        .reset    (reset),
        .en_i     (arb_en),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // Fetches are always aligned word reads with no write data.
    always_comb begin
        cap_addr  = bus.ifu_req_addr;
        cap_we    = 1'b0;
        cap_size  = SZ_W;
        cap_wdata = '0;
        if (pick_lsu) begin
            cap_addr  = bus.lsu_req_addr;
            cap_we    = bus.lsu_req_we;
            cap_size  = bus.lsu_req_size;
            cap_wdata = bus.lsu_req_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = pick_lsu ? OWN_LSU : OWN_IFU;
                    addr_d  = cap_addr;
                    we_d    = cap_we;
                    size_d  = cap_size;
                    wdata_d = cap_wdata;
                    cnt_d   = '0;
                    if (misaligned(cap_size, cap_addr[1:0])) begin
                        state_d  = ST_ERR;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response on the final count still wins over the timeout.
                if (bus.mem_resp_valid) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = bus.mem_resp_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                    rdata_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_LSU;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.ifu_req_ready = gnt[0];
    assign bus.lsu_req_ready = gnt[1];

    assign bus.mem_req_valid = (state_q == ST_ISSUE);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_size      = size_q;
    assign bus.mem_wdata     = wdata_q;

    assign bus.ifu_resp_valid = rvalid_q && (owner_q == OWN_IFU);
    assign bus.ifu_resp_err   = rerr_q && (owner_q == OWN_IFU);
    assign bus.ifu_resp_data  = rdata_q;
    assign bus.lsu_resp_valid = rvalid_q && (owner_q == OWN_LSU);
    assign bus.lsu_resp_err   = rerr_q && (owner_q == OWN_LSU);
    assign bus.lsu_resp_data  = rdata_q;

endmodule

// File: tb/tb_ysyx_25060173_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (TIMEOUT = 4).
// Table of single transactions plus arbitration, timeout and reset cases.
module tb_ysyx_25060173_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ysyx_25060173_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_25060173_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        lsu;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] mdata;
        logic        e_err;
        logic        e_issue;
        int          e_lat;
        logic [31:0] e_data;
        logic [1:0]  e_size;
        logic        e_we;
    } vec_t;

    vec_t vecs[11];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_req_addr   = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_req_addr   = '0;
        bus.lsu_req_we     = 1'b0;
        bus.lsu_req_size   = 2'd0;
        bus.lsu_req_wdata  = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic accept(input logic lsu, input logic [31:0] addr,
                          input logic we, input logic [1:0] size,
                          input logic [31:0] wdata);
        bit ok;
        ok = 0;
        if (lsu) begin
            bus.lsu_req_valid = 1'b1;
            bus.lsu_req_addr  = addr;
            bus.lsu_req_we    = we;
            bus.lsu_req_size  = size;
            bus.lsu_req_wdata = wdata;
        end else begin
            bus.ifu_req_valid = 1'b1;
            bus.ifu_req_addr  = addr;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (lsu ? bus.lsu_req_ready : bus.ifu_req_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
        end
        chk("req_ready", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] d);
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = d;
        @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got, seen, issued;
        int lat, rc, wc;
        logic [31:0] e_wd;
        got = 0; seen = 0; issued = 0;
        lat = 0; rc = 0; wc = 0;
        e_wd = v.lsu ? v.wdata : 32'h0;
        accept(v.lsu, v.addr, v.we, v.size, v.wdata);
        for (int k = 1; k <= 40; k++) begin
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
                got = 1;
                lat = k;
                break;
            end
            if (bus.mem_req_valid) begin
                seen = 1;
                rc++;
                chk($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
                chk($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, e_wd);
                chk($sformatf("v%0d_mem_we", idx), 32'(bus.mem_we), 32'(v.e_we));
                chk($sformatf("v%0d_mem_size", idx), 32'(bus.mem_size),
                    32'(v.e_size));
                if (rc == v.rdy_dly + 1) begin
                    bus.mem_req_ready = 1'b1;
                    issued = 1;
                end
            end else if (issued) begin
                wc++;
                if (wc == v.rsp_dly + 1) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = v.mdata;
                end
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("v%0d_resp_seen", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.e_lat));
        chk($sformatf("v%0d_mem_used", idx), 32'(seen), 32'(v.e_issue));
        chk($sformatf("v%0d_ifu_rv", idx), 32'(bus.ifu_resp_valid),
            32'(!v.lsu));
        chk($sformatf("v%0d_lsu_rv", idx), 32'(bus.lsu_resp_valid),
            32'(v.lsu));
        if (v.lsu) begin
            chk($sformatf("v%0d_err", idx), 32'(bus.lsu_resp_err), 32'(v.e_err));
            chk($sformatf("v%0d_data", idx), bus.lsu_resp_data, v.e_data);
        end else begin
            chk($sformatf("v%0d_err", idx), 32'(bus.ifu_resp_err), 32'(v.e_err));
            chk($sformatf("v%0d_data", idx), bus.ifu_resp_data, v.e_data);
        end
        if (v.e_issue) begin
            chk($sformatf("v%0d_rdy_at_resp", idx),
                32'(bus.ifu_req_ready | bus.lsu_req_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_pulse_end", idx),
            32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // lsu addr we size wdata rdy rsp mdata err issue lat data esize ewe
        vecs[0]  = '{1'b0, 32'h80000000, 1'b0, 2'd2, 32'h0, 0, 0,
                     32'h00100093, 1'b0, 1'b1, 3, 32'h00100093, 2'd2, 1'b0};
        vecs[1]  = '{1'b1, 32'h80000101, 1'b1, 2'd1, 32'h0000beef, 0, 0,
                     32'h0, 1'b1, 1'b0, 1, 32'h0, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 32'h80000004, 1'b0, 2'd2, 32'h0, 0, 0,
                     32'hdeadbeef, 1'b0, 1'b1, 3, 32'hdeadbeef, 2'd2, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000008, 1'b1, 2'd2, 32'h12345678, 5, 2,
                     32'h0, 1'b0, 1'b1, 10, 32'h0, 2'd2, 1'b1};
        vecs[4]  = '{1'b1, 32'h80000003, 1'b1, 2'd0, 32'h000000ab, 0, 1,
                     32'h0, 1'b0, 1'b1, 4, 32'h0, 2'd0, 1'b1};
        vecs[5]  = '{1'b1, 32'h80000000, 1'b0, 2'd3, 32'h0, 0, 0,
                     32'h0, 1'b1, 1'b0, 1, 32'h0, 2'd3, 1'b0};
        vecs[6]  = '{1'b1, 32'h80000002, 1'b0, 2'd2, 32'h0, 0, 0,
                     32'h0, 1'b1, 1'b0, 1, 32'h0, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 32'h80000002, 1'b0, 2'd2, 32'h0, 0, 0,
                     32'h0, 1'b1, 1'b0, 1, 32'h0, 2'd2, 1'b0};
        vecs[8]  = '{1'b1, 32'h80000102, 1'b0, 2'd1, 32'h0, 1, 0,
                     32'hcafe0000, 1'b0, 1'b1, 4, 32'hcafe0000, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 32'h80000040, 1'b0, 2'd2, 32'h0, 0, 99,
                     32'h0, 1'b1, 1'b1, 6, 32'h0, 2'd2, 1'b0};
        vecs[10] = '{1'b1, 32'h80000000, 1'b1, 2'd2, 32'ha5a5a5a5, 0, 2,
                     32'h00000001, 1'b0, 1'b1, 5, 32'h00000001, 2'd2, 1'b1};

        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ifu_rdy", 32'(bus.ifu_req_ready), 32'd0);
        chk("rst_lsu_rdy", 32'(bus.lsu_req_ready), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_size", 32'(bus.mem_size), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_resp_valid",
            32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
        chk("rst_resp_err", 32'({bus.ifu_resp_err, bus.lsu_resp_err}), 32'd0);
        chk("rst_ifu_data", bus.ifu_resp_data, 32'd0);
        chk("rst_lsu_data", bus.lsu_resp_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_lsu_rdy", 32'(bus.lsu_req_ready), 32'd1);
        chk("post_rst_ifu_rdy", 32'(bus.ifu_req_ready), 32'd0);

        // Both request together: LSU first, then alternate.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_addr  = 32'h80000000;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 32'h80000010;
        bus.lsu_req_size  = 2'd2;
        #1;
        chk("arb1_lsu_rdy", 32'(bus.lsu_req_ready), 32'd1);
        chk("arb1_ifu_rdy", 32'(bus.ifu_req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("arb1_addr", bus.mem_addr, 32'h80000010);
        chk("arb1_busy_rdy",
            32'(bus.ifu_req_ready | bus.lsu_req_ready), 32'd0);
        serve(32'h11111111);
        chk("arb1_lsu_rv", 32'(bus.lsu_resp_valid), 32'd1);
        chk("arb1_ifu_rv", 32'(bus.ifu_resp_valid), 32'd0);
        chk("arb1_data", bus.lsu_resp_data, 32'h11111111);
        chk("arb2_ifu_rdy", 32'(bus.ifu_req_ready), 32'd1);
        chk("arb2_lsu_rdy", 32'(bus.lsu_req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("arb2_addr", bus.mem_addr, 32'h80000000);
        chk("arb2_size", 32'(bus.mem_size), 32'd2);
        serve(32'h22222222);
        chk("arb2_ifu_rv", 32'(bus.ifu_resp_valid), 32'd1);
        chk("arb2_lsu_rv", 32'(bus.lsu_resp_valid), 32'd0);
        chk("arb2_data", bus.ifu_resp_data, 32'h22222222);
        chk("arb3_lsu_rdy", 32'(bus.lsu_req_ready), 32'd1);
        chk("arb3_ifu_rdy", 32'(bus.ifu_req_ready), 32'd0);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Timeout followed by a late response that must be dropped.
        accept(1'b0, 32'h80000020, 1'b0, 2'd2, 32'h0);
        chk("to_issue", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_quiet%0d", i), 32'(bus.ifu_resp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("to_rv", 32'(bus.ifu_resp_valid), 32'd1);
        chk("to_err", 32'(bus.ifu_resp_err), 32'd1);
        chk("to_data", bus.ifu_resp_data, 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h00000055;
        @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b0;
        chk("late_rv", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
        chk("late_err", 32'({bus.ifu_resp_err, bus.lsu_resp_err}), 32'd0);
        chk("late_mem_valid", 32'(bus.mem_req_valid), 32'd0);

        // Reset while waiting on memory.
        accept(1'b1, 32'h80000030, 1'b1, 2'd2, 32'h0badf00d);
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("mid_rst_mem_addr", bus.mem_addr, 32'd0);
        chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_rdy", 32'(bus.ifu_req_ready | bus.lsu_req_ready), 32'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h77777777;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.mem_resp_valid = 1'b0;
            chk($sformatf("mid_rst_quiet%0d", i),
                32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
        end
        run_vec(vecs[0], 99);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
